fpu_multilane_eu: RTL

Parametrised floating-point execution-unit front-end. It sits between the FP reservation station and NUM_LANES independent FPU datapath lanes, each with its own latency. It buffers issued operations in an input FIFO and dispatches each one to a free lane. Results are collected in per-lane output FIFOs, using credit-based flow control so a lane never stalls. Results go back to the RS/CDB through a round-robin arbiter. Flush support squashes operations still in flight in the lanes.

---
 rtl/fpu_multilane_eu.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/fpu_multilane_eu.sv
// fpu_multilane_eu
// Front-end between the FP reservation station and NUM_LANES independent FPU
// lanes. Issued ops wait in an input FIFO. The head op goes to the
// lowest-index lane that is ready and has a free credit. Lane results land in
// per-lane output FIFOs and are returned through a round-robin arbiter. A flush
// empties every FIFO and marks the ops still in the lanes to be discarded when
// they come back.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i
//   valid_i/ready_o, ctl_i, rm_i, tag_i, rs1_i..rs3_i      : issue side
//   lane_valid_o/lane_ready_i, lane_ctl_o..lane_rs3_o       : dispatch (payload broadcast)
//   lane_res_valid_i, lane_result_i, lane_tag_i, lane_fflags_i : lane results (no backpressure)
//   valid_o/ready_i, result_o, tag_o, fflags_o              : result side
//   busy_o                                                 : any op buffered or in flight
module fpu_multilane_eu #(
  parameter int NUM_LANES = 2,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int FLEN      = 64,
  parameter int CTL_W     = 6,
  parameter int TAG_W     = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [CTL_W-1:0]           ctl_i,
  input  logic [2:0]                 rm_i,
  input  logic [TAG_W-1:0]           tag_i,
  input  logic [FLEN-1:0]            rs1_i,
  input  logic [FLEN-1:0]            rs2_i,
  input  logic [FLEN-1:0]            rs3_i,
  output logic [NUM_LANES-1:0]       lane_valid_o,
  input  logic [NUM_LANES-1:0]       lane_ready_i,
  output logic [CTL_W-1:0]           lane_ctl_o,
  output logic [2:0]                 lane_rm_o,
  output logic [TAG_W-1:0]           lane_tag_o,
  output logic [FLEN-1:0]            lane_rs1_o,
  output logic [FLEN-1:0]            lane_rs2_o,
  output logic [FLEN-1:0]            lane_rs3_o,
  input  logic [NUM_LANES-1:0]       lane_res_valid_i,
  input  logic [NUM_LANES*FLEN-1:0]  lane_result_i,
  input  logic [NUM_LANES*TAG_W-1:0] lane_tag_i,
  input  logic [NUM_LANES*5-1:0]     lane_fflags_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [FLEN-1:0]            result_o,
  output logic [TAG_W-1:0]           tag_o,
  output logic [4:0]                 fflags_o,
  output logic                       busy_o
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam int RRW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int IW  = CTL_W + 3 + TAG_W + 3 * FLEN;
  localparam int OW  = FLEN + TAG_W + 5;

  // Input FIFO; the extra pointer bit is the wrap bit for full/empty
  logic [IW-1:0]  in_mem [IN_DEPTH];
  logic [IAW:0]   in_wp, in_rp;
  logic           in_empty, in_full, in_push, in_pop;

  // Per-lane output FIFOs and credit bookkeeping
  logic [OW-1:0]  out_mem [NUM_LANES][OUT_DEPTH];
  logic [OAW:0]   out_wp [NUM_LANES];
  logic [OAW:0]   out_rp [NUM_LANES];
  logic [CW-1:0]  out_cnt [NUM_LANES];
  logic [CW-1:0]  inflight [NUM_LANES];
  logic [CW-1:0]  squash [NUM_LANES];
  logic [NUM_LANES-1:0] nonempty, eligible, out_push;
  logic           any_inflight, taken;

  // Output arbiter state; lock holds the grant while the RS stalls
  logic [RRW-1:0] rr, lock_lane, winner, rr_next;
  logic           lock, out_pop;
  logic [OW-1:0]  sel;

  // First non-empty lane at or after start, in circular order
  function automatic logic [RRW-1:0] rr_pick(input logic [NUM_LANES-1:0] ne,
                                             input logic [RRW-1:0] start);
    logic [RRW:0]   s;
    logic [RRW-1:0] idx, pick;
    logic           hit;
    pick = start;
    hit  = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      s    = {1'b0, start} + (RRW+1)'(k);
      s    = (s >= (RRW+1)'(NUM_LANES)) ? s - (RRW+1)'(NUM_LANES) : s;
      idx  = s[RRW-1:0];
      pick = (ne[idx] && !hit) ? idx : pick;
      hit  = hit | ne[idx];
    end
    return pick;
  endfunction

  assign in_empty = (in_wp == in_rp);
  assign in_full  = (in_wp[IAW] != in_rp[IAW]) && (in_wp[IAW-1:0] == in_rp[IAW-1:0]);
  assign ready_o  = !in_full;
  assign in_push  = valid_i && !in_full && !flush_i;
  assign in_pop   = |lane_valid_o;
  assign {lane_ctl_o, lane_rm_o, lane_tag_o, lane_rs1_o, lane_rs2_o, lane_rs3_o} =
         in_mem[in_rp[IAW-1:0]];
  assign busy_o   = !in_empty || (|nonempty) || any_inflight;
  assign out_pop  = valid_o && ready_i;
  assign rr_next  = (winner == RRW'(NUM_LANES - 1)) ? '0 : winner + RRW'(1);

  // Per-lane occupancy, credit eligibility and result-capture enables
  always_comb begin
    nonempty     = '0;
    eligible     = '0;
    out_push     = '0;
    any_inflight = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      out_cnt[l]   = CW'(out_wp[l] - out_rp[l]);
      // registered counts only: a same-cycle pop frees its credit next cycle
      eligible[l]  = lane_ready_i[l] &&
                     (({1'b0, inflight[l]} + {1'b0, out_cnt[l]}) < (CW+1)'(OUT_DEPTH));
      nonempty[l]  = (out_wp[l] != out_rp[l]);
      out_push[l]  = lane_res_valid_i[l] && (squash[l] == '0) && !flush_i;
      any_inflight = any_inflight | (inflight[l] != '0);
    end
  end

  // Head op goes to the lowest-index eligible lane (one-hot or zero)
  always_comb begin
    taken        = 1'b0;
    lane_valid_o = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_valid_o[l] = eligible[l] && !taken && !in_empty && !flush_i;
      taken           = taken | eligible[l];
    end
  end

  // Result selection; payload reads as zero whenever nothing is offered
  always_comb begin
    winner = lock ? lock_lane : rr_pick(nonempty, rr);
    valid_o = nonempty[winner] && !flush_i;
    sel = out_mem[winner][out_rp[winner][OAW-1:0]];
    {result_o, tag_o, fflags_o} = valid_o ? sel : '0;
  end

  // FIFO storage writes (data arrays carry no reset)
  always_ff @(posedge clk_i) begin
    if (in_push) begin
      in_mem[in_wp[IAW-1:0]] <= {ctl_i, rm_i, tag_i, rs1_i, rs2_i, rs3_i};
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      if (out_push[l]) begin
        out_mem[l][out_wp[l][OAW-1:0]] <= {lane_result_i[l*FLEN +: FLEN],
                                           lane_tag_i[l*TAG_W +: TAG_W],
                                           lane_fflags_i[l*5 +: 5]};
      end
    end
  end

  // Pointers, credits, squash counters and arbiter state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_wp     <= '0;
      in_rp     <= '0;
      rr        <= '0;
      lock      <= 1'b0;
      lock_lane <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        out_wp[l]   <= '0;
        out_rp[l]   <= '0;
        inflight[l] <= '0;
        squash[l]   <= '0;
      end
    end else begin
      // inflight keeps tracking squashed ops until they come back
      for (int l = 0; l < NUM_LANES; l++) begin
        inflight[l] <= inflight[l] + CW'(lane_valid_o[l]) - CW'(lane_res_valid_i[l]);
      end
      if (flush_i) begin
        in_wp <= '0;
        in_rp <= '0;
        lock  <= 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
          out_wp[l] <= '0;
          out_rp[l] <= '0;
          // a result arriving in the flush cycle is already dropped
          squash[l] <= inflight[l] - CW'(lane_res_valid_i[l]);
        end
      end else begin
        if (in_push) in_wp <= in_wp + (IAW+1)'(1);
        if (in_pop)  in_rp <= in_rp + (IAW+1)'(1);
        for (int l = 0; l < NUM_LANES; l++) begin
          if (out_push[l]) begin
            out_wp[l] <= out_wp[l] + (OAW+1)'(1);
          end else if (lane_res_valid_i[l]) begin
            squash[l] <= squash[l] - CW'(1);
          end
          if (out_pop && (winner == RRW'(l))) begin
            out_rp[l] <= out_rp[l] + (OAW+1)'(1);
          end
        end
        if (out_pop) begin
          rr   <= rr_next;
          lock <= 1'b0;
        end else if (valid_o) begin
          lock      <= 1'b1;
          lock_lane <= winner;
        end
      end
    end
  end

endmodule
